// File: rtl/pixel_pkg.sv
// Shared encodings and defaults for the pixel colour mapper.
// The optional auto-contrast feature is enabled with PIXEL_AGC_EN.
package pixel_pkg;
  localparam int ADC_W_DEF = 12;
  localparam int VGA_W_DEF = 6;

  typedef enum logic [1:0] {
    MODE_GRAY = 2'd0,
    MODE_RGB  = 2'd1,
    MODE_IRON = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  // Iron palette quadrants, selected by the top two bits of the index
  localparam logic [1:0] IRON_Q0 = 2'd0;
  localparam logic [1:0] IRON_Q1 = 2'd1;
  localparam logic [1:0] IRON_Q2 = 2'd2;
  localparam logic [1:0] IRON_Q3 = 2'd3;

  // The reserved encoding is applied as gray
  function automatic mode_e mode_map(input logic [1:0] m);
    return (m == MODE_RSVD) ? MODE_GRAY : mode_e'(m);
  endfunction
endpackage

// File: rtl/frame_range_tracker.sv
// Per-frame min/max tracker producing offset (lo) and gain shift (sh).
// Only instantiated when PIXEL_AGC_EN is defined.
module frame_range_tracker #(
  parameter int ADC_W = 12,
  parameter int SH_W  = $clog2(ADC_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             strobe,
  input  logic [ADC_W-1:0] data,
  output logic [ADC_W-1:0] lo,
  output logic [SH_W-1:0]  sh
);
  logic [ADC_W-1:0] mn, mx, lo_q, rng, lo_nxt;
  logic [SH_W-1:0]  sh_q, msb, sh_nxt;
  logic             spread;

  always_comb begin
    spread = mx > mn;
    rng    = spread ? (mx - mn) : '0;
    msb    = '0;
    for (int i = 0; i < ADC_W; i++)
      if (rng[i]) msb = SH_W'(i);
    lo_nxt = spread ? mn : '0;
    sh_nxt = spread ? (SH_W'(ADC_W - 1) - msb) : '0;
  end

  // The pixel on frame_start already belongs to the new frame, so it sees the new values
  assign lo = frame_start ? lo_nxt : lo_q;
  assign sh = frame_start ? sh_nxt : sh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mn   <= '1;
      mx   <= '0;
      lo_q <= '0;
      sh_q <= '0;
    end else if (frame_start) begin
      lo_q <= lo_nxt;
      sh_q <= sh_nxt;
      mn   <= strobe ? data : '1;
      mx   <= strobe ? data : '0;
    end else if (strobe) begin
      if (data < mn) mn <= data;
      if (data > mx) mx <= data;
    end
  end
endmodule

// File: rtl/pixel_colour_mapper.sv
// Two-stage registered gray / iron / RGB pixel mapper feeding the VGA DAC.
// Define PIXEL_AGC_EN for per-frame auto-contrast.
module pixel_colour_mapper
  import pixel_pkg::*;
#(
  parameter int ADC_W = ADC_W_DEF,
  parameter int VGA_W = VGA_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             pix_valid_i,
  input  logic             enable,
  input  logic [1:0]       mode_i,
  input  logic [ADC_W-1:0] data_i,
  input  logic [VGA_W-1:0] red_in,
  input  logic [VGA_W-1:0] green_in,
  input  logic [VGA_W-1:0] blue_in,
  output logic [VGA_W-1:0] red_o,
  output logic [VGA_W-1:0] green_o,
  output logic [VGA_W-1:0] blue_o,
  output logic             pix_valid_o,
  output logic             enable_o,
  output logic [1:0]       mode_o
);
  localparam int NW     = VGA_W + 2;
  localparam int SH_W   = $clog2(ADC_W);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [NW-1:0]    n;
    mode_e            mode;
    logic [VGA_W-1:0] r, g, b;
  } s1_t;

  mode_e              mode_q, mode_nxt;
  logic [ADC_W-1:0]   lo, diff;
  logic [SH_W-1:0]    sh;
  logic [ADC_W+NW-1:0] top;
  logic [NW-1:0]      n;
  logic [STAGES:1]    vld_pipe, en_pipe;
  s1_t                s1;
  logic [VGA_W-1:0]   cr, cg, cb, f;

`ifdef PIXEL_AGC_EN
  frame_range_tracker #(.ADC_W(ADC_W), .SH_W(SH_W)) u_trk (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .strobe(pix_valid_i & enable), .data(data_i), .lo(lo), .sh(sh)
  );
`else
  assign lo = '0;
  assign sh = '0;
`endif

  assign mode_nxt = frame_start ? mode_map(mode_i) : mode_q;

  // Shift wide enough that nothing is lost; any bit above ADC_W means saturate
  always_comb begin
    diff = (data_i >= lo) ? (data_i - lo) : '0;
    top  = (ADC_W+NW)'(({{ADC_W{1'b0}}, diff} << sh) >> (ADC_W - NW));
    n    = (|top[ADC_W+NW-1:NW]) ? '1 : top[NW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_GRAY;
      s1       <= '0;
      vld_pipe <= '0;
      en_pipe  <= '0;
    end else begin
      mode_q   <= mode_nxt;
      s1       <= '{n: n, mode: mode_nxt, r: red_in, g: green_in, b: blue_in};
      vld_pipe <= {vld_pipe[STAGES-1:1], pix_valid_i};
      en_pipe  <= {en_pipe[STAGES-1:1], enable};
    end
  end

  always_comb begin
    f  = s1.n[VGA_W-1:0];
    cr = s1.n[NW-1:2];
    cg = s1.n[NW-1:2];
    cb = s1.n[NW-1:2];
    case (s1.mode)
      MODE_RGB: begin
        cr = s1.r; cg = s1.g; cb = s1.b;
      end
      MODE_IRON: begin
        case (s1.n[NW-1 -: 2])
          IRON_Q0: begin cr = '0; cg = '0; cb = f;  end
          IRON_Q1: begin cr = f;  cg = '0; cb = '1; end
          IRON_Q2: begin cr = '1; cg = f;  cb = ~f; end
          IRON_Q3: begin cr = '1; cg = '1; cb = f;  end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_o   <= '0;
      green_o <= '0;
      blue_o  <= '0;
    end else if (vld_pipe[1] && en_pipe[1]) begin
      red_o   <= cr;
      green_o <= cg;
      blue_o  <= cb;
    end else begin
      red_o   <= '0;
      green_o <= '0;
      blue_o  <= '0;
    end
  end

  assign pix_valid_o = vld_pipe[STAGES];
  assign enable_o    = en_pipe[STAGES];
  assign mode_o      = mode_q;
endmodule

// File: tb/tb_pixel_colour_mapper.sv
// Directed scoreboard bench for pixel_colour_mapper (ADC_W=12, VGA_W=6).
// Expectations follow PIXEL_AGC_EN when it is defined for the build.
module tb_pixel_colour_mapper;
  logic        clk = 0;
  logic        rst_n;
  logic        frame_start, pix_valid_i, enable;
  logic [1:0]  mode_i;
  logic [11:0] data_i;
  logic [5:0]  red_in, green_in, blue_in;
  logic [5:0]  red_o, green_o, blue_o;
  logic        pix_valid_o, enable_o;
  logic [1:0]  mode_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [5:0] r, g, b;
    logic       v, e;
  } exp_t;
  exp_t sb[$];

  pixel_colour_mapper #(.ADC_W(12), .VGA_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid_i(pix_valid_i),
    .enable(enable), .mode_i(mode_i), .data_i(data_i), .red_in(red_in),
    .green_in(green_in), .blue_in(blue_in), .red_o(red_o), .green_o(green_o),
    .blue_o(blue_o), .pix_valid_o(pix_valid_o), .enable_o(enable_o), .mode_o(mode_o)
  );

  always #5 clk = ~clk;

  task automatic step(input logic fs, input logic [1:0] mi, input logic v, input logic e,
                      input logic [11:0] d, input logic [5:0] ri, input logic [5:0] gi,
                      input logic [5:0] bi, input logic [5:0] er, input logic [5:0] eg,
                      input logic [5:0] eb, input logic [1:0] em);
    exp_t x, o;
    @(negedge clk);
    frame_start = fs; mode_i = mi; pix_valid_i = v; enable = e; data_i = d;
    red_in = ri; green_in = gi; blue_in = bi;
    x = '{r: (v && e) ? er : 6'h0, g: (v && e) ? eg : 6'h0, b: (v && e) ? eb : 6'h0, v: v, e: e};
    sb.push_back(x);
    @(posedge clk); #1;
    checks++;
    assert (mode_o === em) else begin
      errors++;
      $error("FAIL mode_o got %0d want %0d", mode_o, em);
    end
    if (sb.size() >= 2) begin
      x = sb.pop_front();
      o = '{r: red_o, g: green_o, b: blue_o, v: pix_valid_o, e: enable_o};
      checks++;
      assert (o === x) else begin
        errors++;
        $error("FAIL pixel rgb/v/e got %h/%h/%h/%b/%b want %h/%h/%h/%b/%b",
               o.r, o.g, o.b, o.v, o.e, x.r, x.g, x.b, x.v, x.e);
      end
    end
  endtask

  // Plain data pixel, valid and enabled, no external RGB
  task automatic px(input logic fs, input logic [1:0] mi, input logic [11:0] d,
                    input logic [5:0] er, input logic [5:0] eg, input logic [5:0] eb,
                    input logic [1:0] em);
    step(fs, mi, 1'b1, 1'b1, d, 6'h0, 6'h0, 6'h0, er, eg, eb, em);
  endtask

  task automatic check_zero(input string tag);
    checks++;
    assert ({red_o, green_o, blue_o, pix_valid_o, enable_o, mode_o} === 22'h0) else begin
      errors++;
      $error("FAIL %s got %h/%h/%h/%b/%b/%0d want all 0", tag, red_o, green_o, blue_o,
             pix_valid_o, enable_o, mode_o);
    end
  endtask

  task automatic idle_inputs();
    frame_start = 0; pix_valid_i = 0; enable = 0; mode_i = 0; data_i = 0;
    red_in = 0; green_in = 0; blue_in = 0;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    #12;
    check_zero("reset_state");
    @(negedge clk); rst_n = 1;

    // First frame after reset: coincident pixel uses the new IRON mode
    px(1, 2, 12'hABC, 6'h3F, 6'h2B, 6'h14, 2);
    px(0, 0, 12'hABC, 6'h3F, 6'h2B, 6'h14, 2);

    // Asynchronous reset mid-stream clears outputs at once
    #2 rst_n = 0;
    #1 check_zero("async_reset");
    sb.delete();
    idle_inputs();
    @(negedge clk); @(negedge clk); rst_n = 1;

    // GRAY until the first frame_start; mode_i ignored mid-frame
    px(0, 2, 12'hABC, 6'h2A, 6'h2A, 6'h2A, 0);
    px(0, 2, 12'hABC, 6'h2A, 6'h2A, 6'h2A, 0);
    step(0, 0, 1, 0, 12'hABC, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 12'hABC, 0, 0, 0, 0, 0, 0, 0);

    // IRON, all four quadrants
    px(1, 2, 12'hABC, 6'h3F, 6'h2B, 6'h14, 2);
    px(0, 0, 12'h123, 6'h00, 6'h00, 6'h12, 2);
    px(0, 0, 12'h5A0, 6'h1A, 6'h00, 6'h3F, 2);
    px(0, 0, 12'hFFF, 6'h3F, 6'h3F, 6'h3F, 2);
    px(0, 0, 12'hC40, 6'h3F, 6'h3F, 6'h04, 2);

    // RGB pass-through with a valid gap
    step(1, 1, 1, 1, 12'h000, 6'h11, 6'h22, 6'h33, 6'h11, 6'h22, 6'h33, 1);
    step(0, 1, 0, 1, 12'h000, 6'h2A, 6'h15, 6'h3C, 0, 0, 0, 1);
    step(0, 1, 1, 1, 12'h000, 6'h2A, 6'h15, 6'h3C, 6'h2A, 6'h15, 6'h3C, 1);

    // Reserved mode behaves as GRAY
    px(1, 3, 12'hABC, 6'h2A, 6'h2A, 6'h2A, 0);

    // Frame with no counted pixels
    step(1, 0, 0, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 12'h7FF, 0, 0, 0, 0, 0, 0, 0);

    // Measurement frame: min 0x100, max 0x1FF; invalid/blanked samples excluded
    px(1, 0, 12'h100, 6'h04, 6'h04, 6'h04, 0);
    px(0, 0, 12'h1FF, 6'h07, 6'h07, 6'h07, 0);
    step(0, 0, 0, 1, 12'h000, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 12'hFFF, 0, 0, 0, 0, 0, 0, 0);

`ifdef PIXEL_AGC_EN
    // lo=0x100, sh=4
    px(1, 0, 12'h180, 6'h20, 6'h20, 6'h20, 0);
    px(0, 0, 12'h0F0, 6'h00, 6'h00, 6'h00, 0);
    px(0, 0, 12'h3FF, 6'h3F, 6'h3F, 6'h3F, 0);
    px(0, 0, 12'h140, 6'h10, 6'h10, 6'h10, 0);
    // lo=0x0F0, sh=2: 0x555 saturates; frame is constant 0x555
    px(1, 0, 12'h555, 6'h3F, 6'h3F, 6'h3F, 0);
    px(0, 0, 12'h555, 6'h3F, 6'h3F, 6'h3F, 0);
`else
    px(1, 0, 12'h180, 6'h06, 6'h06, 6'h06, 0);
    px(0, 0, 12'h0F0, 6'h03, 6'h03, 6'h03, 0);
    px(0, 0, 12'h3FF, 6'h0F, 6'h0F, 6'h0F, 0);
    px(0, 0, 12'h140, 6'h05, 6'h05, 6'h05, 0);
    px(1, 0, 12'h555, 6'h15, 6'h15, 6'h15, 0);
    px(0, 0, 12'h555, 6'h15, 6'h15, 6'h15, 0);
`endif
    // Constant frame gives lo=0, sh=0
    px(1, 0, 12'h555, 6'h15, 6'h15, 6'h15, 0);
    px(0, 0, 12'h555, 6'h15, 6'h15, 6'h15, 0);

    step(0, 0, 0, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
